imm_gen_pipe: RTL and testbench

- Parametrised, pipelined immediate generator for the decode stage.
- Handles all RV32I/RV64I immediate formats (I, shift, S, B, U, J) at width XLEN, not only ADDI/shift/LW/SW/BEQ.
- Tags each result with a format code and an illegal-opcode flag.
- One registered output stage plus a one-entry skid buffer, so decode can be stalled by a valid/ready handshake without losing instructions.

---
 rtl/imm_gen_pipe.sv | 161 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator: decodes the immediate, format and legality of an
// instruction, with a registered output stage and a one-entry skid buffer behind a valid/ready handshake.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [31:0]      inst_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  imm_o,
    output logic [2:0]       fmt_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_SHIFT = 3'd2;
    localparam logic [2:0] FMT_S     = 3'd3;
    localparam logic [2:0] FMT_B     = 3'd4;
    localparam logic [2:0] FMT_U     = 3'd5;
    localparam logic [2:0] FMT_J     = 3'd6;
    localparam logic [2:0] FMT_NONE  = 3'd7;

    function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    // RV64 shifts use a 6-bit shamt; RV32 ignores inst[25].
    function automatic logic [XLEN-1:0] zext_shamt(input logic [31:0] inst);
        logic [5:0] sh;
        sh = {(XLEN == 64) ? inst[25] : 1'b0, inst[24:20]};
        return XLEN'(sh);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic signed [XLEN-1:0] imm_d;
    logic [2:0]             fmt_d;
    logic                   ill_d;
    logic [6:0]             opc;
    logic [2:0]             f3;

    assign opc = inst_i[6:0];
    assign f3  = inst_i[14:12];

    always_comb begin
        imm_d = '0;
        fmt_d = FMT_NONE;
        ill_d = 1'b0;
        case (opc)
            7'b0010011: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    fmt_d = FMT_SHIFT;
                    imm_d = zext_shamt(inst_i);
                end else begin
                    fmt_d = FMT_I;
                    imm_d = sext32({{20{inst_i[31]}}, inst_i[31:20]});
                end
            end
            7'b0000011, 7'b1100111: begin
                fmt_d = FMT_I;
                imm_d = sext32({{20{inst_i[31]}}, inst_i[31:20]});
            end
            7'b0100011: begin
                fmt_d = FMT_S;
                imm_d = sext32({{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]});
            end
            7'b1100011: begin
                fmt_d = FMT_B;
                imm_d = sext32({{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                                inst_i[11:8], 1'b0});
            end
            7'b0110111, 7'b0010111: begin
                fmt_d = FMT_U;
                imm_d = sext32({inst_i[31:12], 12'b0});
            end
            7'b1101111: begin
                fmt_d = FMT_J;
                imm_d = sext32({{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                                inst_i[30:21], 1'b0});
            end
            7'b0110011: begin
                fmt_d = FMT_R;
            end
            default: begin
                ill_d = 1'b1;
            end
        endcase
    end

    // Stage p1: output register O and skid register K
    logic                   vld_p1, ill_p1;
    logic signed [XLEN-1:0] imm_p1;
    logic [2:0]             fmt_p1;
    logic                   vld_sk, ill_sk;
    logic signed [XLEN-1:0] imm_sk;
    logic [2:0]             fmt_sk;
    logic [CNT_W-1:0]       cnt;
    logic                   accept, load_o, load_k, pop_k;

    assign ready_o = !vld_sk;
    assign accept  = valid_i && ready_o;
    assign load_o  = accept && (!vld_p1 || ready_i);
    assign load_k  = accept && vld_p1 && !ready_i;
    assign pop_k   = vld_sk && ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_p1 <= 1'b0;
            imm_p1 <= '0;
            fmt_p1 <= FMT_R;
            ill_p1 <= 1'b0;
            vld_sk <= 1'b0;
            cnt    <= '0;
        end else begin
            if (pop_k) begin
                imm_p1 <= imm_sk;
                fmt_p1 <= fmt_sk;
                ill_p1 <= ill_sk;
            end else if (load_o) begin
                vld_p1 <= 1'b1;
                imm_p1 <= imm_d;
                fmt_p1 <= fmt_d;
                ill_p1 <= ill_d;
            end else if (ready_i) begin
                vld_p1 <= 1'b0;
            end

            if (pop_k)
                vld_sk <= 1'b0;
            else if (load_k)
                vld_sk <= 1'b1;

            if (accept && ill_d)
                cnt <= sat_inc(cnt);
        end
    end

    // Skid payload is only observed while vld_sk is set, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (load_k) begin
            imm_sk <= imm_d;
            fmt_sk <= fmt_d;
            ill_sk <= ill_d;
        end
    end

    assign valid_o       = vld_p1;
    assign imm_o         = imm_p1;
    assign fmt_o         = fmt_p1;
    assign illegal_o     = ill_p1;
    assign illegal_cnt_o = cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance share the same stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic [31:0] inst_i = 32'h0;

    logic        ready32, valid32, ill32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [7:0]  cnt32;
    logic        ready64, valid64, ill64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [7:0]  cnt64;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut32 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready32), .inst_i(inst_i),
        .valid_o(valid32), .ready_i(ready_i), .imm_o(imm32), .fmt_o(fmt32),
        .illegal_o(ill32), .illegal_cnt_o(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(8)) dut64 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready64), .inst_i(inst_i),
        .valid_o(valid64), .ready_i(ready_i), .imm_o(imm64), .fmt_o(fmt64),
        .illegal_o(ill64), .illegal_cnt_o(cnt64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] e32, input logic [63:0] e64,
                           input logic [2:0] fmt, input logic ill);
        chk({tag, "_valid32"}, 64'(valid32), 64'd1);
        chk({tag, "_imm32"}, 64'(imm32), 64'(e32));
        chk({tag, "_fmt32"}, 64'(fmt32), 64'(fmt));
        chk({tag, "_ill32"}, 64'(ill32), 64'(ill));
        chk({tag, "_valid64"}, 64'(valid64), 64'd1);
        chk({tag, "_imm64"}, imm64, e64);
        chk({tag, "_fmt64"}, 64'(fmt64), 64'(fmt));
    endtask

    task automatic issue(input logic [31:0] inst);
        valid_i = 1'b1;
        inst_i  = inst;
        ready_i = 1'b1;
        step();
    endtask

    int          idx_t [10] = '{1, 2, 3, 3, 3, 3, 4, 5, 6, 0};
    logic        rdy_t [10] = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    int          out_t [10] = '{1, 1, 1, 1, 2, 3, 4, 5, 6, 0};
    logic        ro_t  [10] = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 1};

    initial begin
        #1 rst_i = 1'b0;
        step();
        step();
        chk("rst_valid", 64'(valid32), 64'd0);
        chk("rst_ready", 64'(ready32), 64'd1);
        chk("rst_imm", 64'(imm32), 64'd0);
        chk("rst_fmt", 64'(fmt32), 64'd0);
        chk("rst_ill", 64'(ill32), 64'd0);
        chk("rst_cnt", 64'(cnt32), 64'd0);
        #3 rst_i = 1'b1;

        issue(32'hFFF00093);
        chk_res("addi", 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
        issue(32'h41F0D093);
        chk_res("srai31", 32'h0000001F, 64'h000000000000001F, 3'd2, 1'b0);
        issue(32'h43F0D093);
        chk_res("srai63", 32'h0000001F, 64'h000000000000003F, 3'd2, 1'b0);
        issue(32'hFE000EE3);
        chk_res("beq", 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd4, 1'b0);
        issue(32'h123450B7);
        chk_res("lui", 32'h12345000, 64'h0000000012345000, 3'd5, 1'b0);
        issue(32'h800000B7);
        chk_res("lui_neg", 32'h80000000, 64'hFFFFFFFF80000000, 3'd5, 1'b0);
        issue(32'hFF9FF06F);
        chk_res("jal", 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd6, 1'b0);
        issue(32'h0020A423);
        chk_res("sw_pos", 32'h00000008, 64'h0000000000000008, 3'd3, 1'b0);
        issue(32'hFE20AE23);
        chk_res("sw_neg", 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
        issue(32'h002081B3);
        chk_res("add", 32'h0, 64'h0, 3'd0, 1'b0);

        valid_i = 1'b0;
        ready_i = 1'b1;
        step();
        chk("drain_valid", 64'(valid32), 64'd0);

        for (int e = 0; e < 10; e++) begin
            valid_i = (idx_t[e] != 0);
            inst_i  = (32'(idx_t[e]) << 20) | 32'h00000093;
            ready_i = rdy_t[e];
            step();
            chk($sformatf("stall%0d_ready", e + 1), 64'(ready32), 64'(ro_t[e]));
            chk($sformatf("stall%0d_valid", e + 1), 64'(valid32), 64'(out_t[e] != 0));
            if (out_t[e] != 0)
                chk($sformatf("stall%0d_imm", e + 1), 64'(imm32), 64'(out_t[e]));
        end

        for (int k = 1; k <= 260; k++) begin
            issue(32'h0000007F);
            chk($sformatf("ill%0d_valid", k), 64'(valid32), 64'd1);
            chk($sformatf("ill%0d_flag", k), 64'(ill32), 64'd1);
            chk($sformatf("ill%0d_fmt", k), 64'(fmt32), 64'd7);
            chk($sformatf("ill%0d_imm", k), 64'(imm32), 64'd0);
            chk($sformatf("ill%0d_cnt32", k), 64'(cnt32), 64'((k < 255) ? k : 255));
            chk($sformatf("ill%0d_cnt64", k), 64'(cnt64), 64'((k < 255) ? k : 255));
        end

        valid_i = 1'b1;
        inst_i  = 32'h00100093;
        ready_i = 1'b0;
        step();
        chk("full_ready", 64'(ready32), 64'd0);
        chk("full_valid", 64'(valid32), 64'd1);
        chk("full_ill", 64'(ill32), 64'd1);
        #2 rst_i = 1'b0;
        #1;
        chk("arst_valid", 64'(valid32), 64'd0);
        chk("arst_ready", 64'(ready32), 64'd1);
        chk("arst_cnt", 64'(cnt32), 64'd0);
        chk("arst_imm", 64'(imm32), 64'd0);
        chk("arst_valid64", 64'(valid64), 64'd0);
        #2 rst_i = 1'b1;
        issue(32'h123450B7);
        chk_res("post_rst_lui", 32'h12345000, 64'h0000000012345000, 3'd5, 1'b0);
        chk("post_rst_cnt", 64'(cnt32), 64'd0);

        valid_i = 1'b0;
        step();
        chk("final_valid", 64'(valid32), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
